if_block: RTL and testbench

Instruction-fetch stage of the MIPS64 pipeline, sitting directly upstream of the instruction-decode stage. Owns the 64-bit program counter, issues one outstanding request at a time to the instruction memory over a req/ack handshake, and presents each fetched 32-bit instruction with its PC and a valid flag in the IF/ID output register consumed by decode. Supports downstream stall, branch/jump redirect with flush, and variable-latency memory, including zero-wait-state ack.

---
 rtl/if_block.sv | 155 +++++++++++++++
 tb/tb_if_block.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/if_block.sv
// MIPS64 instruction-fetch stage: owns the PC, runs one outstanding req/ack fetch
// at a time, and presents fetched instructions in the IF/ID register.
module if_block #(
    parameter int unsigned      WIDTH    = 64,
    parameter logic [WIDTH-1:0] RESET_PC = '0
) (
    input  logic             p_clk,
    input  logic             p_reset,
    input  logic             p_Stall,
    input  logic             p_Redirect,
    input  logic [WIDTH-1:0] p_RedirectPC,
    output logic             p_IMEM_Req,
    output logic [WIDTH-1:0] p_IMEM_Addr,
    input  logic             p_IMEM_Ack,
    input  logic [31:0]      p_IMEM_Data,
    output logic [31:0]      p_IF_OUT_Instruction,
    output logic [WIDTH-1:0] p_IF_OUT_PC,
    output logic             p_IF_OUT_Valid
);

    localparam int unsigned INSTR_W = 32;

    localparam logic [1:0] ST_FETCH   = 2'd0;
    localparam logic [1:0] ST_HOLD    = 2'd1;
    localparam logic [1:0] ST_DISCARD = 2'd2;

    logic [1:0]         state, state_n;
    logic [WIDTH-1:0]   pc, pc_n;
    logic [WIDTH-1:0]   addr, addr_n;
    logic               req, req_n;
    logic [INSTR_W-1:0] buf_instr, buf_instr_n;
    logic [WIDTH-1:0]   buf_pc, buf_pc_n;
    logic [INSTR_W-1:0] out_instr, out_instr_n;
    logic [WIDTH-1:0]   out_pc, out_pc_n;
    logic               out_valid, out_valid_n;

    logic [WIDTH-1:0]   target;
    logic [WIDTH-1:0]   addr_inc;
    logic               ack;

    // An ack only counts against a request we are actually driving.
    assign ack      = p_IMEM_Ack & req;
    assign target   = p_RedirectPC & ~WIDTH'(3);
    assign addr_inc = addr + WIDTH'(4);

    always_ff @(posedge p_clk) begin
        if (p_reset) begin
            state     <= ST_FETCH;
            pc        <= RESET_PC;
            addr      <= RESET_PC;
            req       <= 1'b0;
            buf_instr <= '0;
            buf_pc    <= '0;
            out_instr <= '0;
            out_pc    <= '0;
            out_valid <= 1'b0;
        end else begin
            state     <= state_n;
            pc        <= pc_n;
            addr      <= addr_n;
            req       <= req_n;
            buf_instr <= buf_instr_n;
            buf_pc    <= buf_pc_n;
            out_instr <= out_instr_n;
            out_pc    <= out_pc_n;
            out_valid <= out_valid_n;
        end
    end

    always_comb begin
        state_n     = state;
        pc_n        = pc;
        addr_n      = addr;
        req_n       = req;
        buf_instr_n = buf_instr;
        buf_pc_n    = buf_pc;
        out_instr_n = out_instr;
        out_pc_n    = out_pc;
        // Without a new instruction the output drains unless decode is stalled.
        out_valid_n = p_Stall ? out_valid : 1'b0;

        case (state)
            ST_FETCH: begin
                if (p_Redirect) begin
                    out_valid_n = 1'b0;
                    pc_n        = target;
                    // With nothing outstanding the new target can be requested at once.
                    if (ack || !req) begin
                        addr_n = target;
                        req_n  = 1'b1;
                    end else begin
                        state_n = ST_DISCARD;
                    end
                end else if (ack) begin
                    pc_n = addr_inc;
                    if (!p_Stall || !out_valid) begin
                        out_instr_n = p_IMEM_Data;
                        out_pc_n    = addr;
                        out_valid_n = 1'b1;
                        addr_n      = addr_inc;
                        req_n       = 1'b1;
                    end else begin
                        buf_instr_n = p_IMEM_Data;
                        buf_pc_n    = addr;
                        state_n     = ST_HOLD;
                        req_n       = 1'b0;
                    end
                end else begin
                    req_n = 1'b1;
                end
            end

            ST_HOLD: begin
                if (p_Redirect) begin
                    out_valid_n = 1'b0;
                    pc_n        = target;
                    addr_n      = target;
                    state_n     = ST_FETCH;
                    req_n       = 1'b1;
                end else if (!p_Stall) begin
                    out_instr_n = buf_instr;
                    out_pc_n    = buf_pc;
                    out_valid_n = 1'b1;
                    addr_n      = pc;
                    state_n     = ST_FETCH;
                    req_n       = 1'b1;
                end
            end

            ST_DISCARD: begin
                // The stale request stays up until memory completes it.
                req_n = 1'b1;
                if (p_Redirect) begin
                    out_valid_n = 1'b0;
                    pc_n        = target;
                end else if (ack) begin
                    addr_n  = pc;
                    state_n = ST_FETCH;
                end
            end

            default: begin
                state_n = ST_FETCH;
                req_n   = 1'b0;
            end
        endcase
    end

    assign p_IMEM_Req           = req;
    assign p_IMEM_Addr          = addr;
    assign p_IF_OUT_Instruction = out_instr;
    assign p_IF_OUT_PC          = out_pc;
    assign p_IF_OUT_Valid       = out_valid;

endmodule

// File: tb/tb_if_block.sv
// Bench for if_block: directed scenarios plus randomized stall/redirect/wait-state
// traffic checked against an event-level model of the fetch stream.
module tb_if_block;

    logic        p_clk;
    logic        p_reset;
    logic        p_Stall;
    logic        p_Redirect;
    logic [63:0] p_RedirectPC;
    logic        p_IMEM_Req;
    logic [63:0] p_IMEM_Addr;
    logic        p_IMEM_Ack;
    logic [31:0] p_IMEM_Data;
    logic [31:0] p_IF_OUT_Instruction;
    logic [63:0] p_IF_OUT_PC;
    logic        p_IF_OUT_Valid;

    logic        req_w;
    logic [63:0] addr_w;
    logic [31:0] data_w;
    logic [31:0] instr_w;
    logic [63:0] pc_w;
    logic        valid_w;

    int nvec  = 0;
    int nfail = 0;

    // Event-level model state
    logic        m_valid, m_buf, m_stale;
    logic [63:0] m_pc, m_buf_pc, stream;
    logic [31:0] m_instr;
    int          consumed;

    function automatic logic [31:0] mem_word(input logic [63:0] a);
        return (a[31:0] * 32'h9E37_79B1) ^ a[63:32] ^ 32'h1234_5678;
    endfunction

    if_block dut (
        .p_clk(p_clk), .p_reset(p_reset), .p_Stall(p_Stall),
        .p_Redirect(p_Redirect), .p_RedirectPC(p_RedirectPC),
        .p_IMEM_Req(p_IMEM_Req), .p_IMEM_Addr(p_IMEM_Addr),
        .p_IMEM_Ack(p_IMEM_Ack), .p_IMEM_Data(p_IMEM_Data),
        .p_IF_OUT_Instruction(p_IF_OUT_Instruction),
        .p_IF_OUT_PC(p_IF_OUT_PC), .p_IF_OUT_Valid(p_IF_OUT_Valid)
    );

    // Second instance near the top of the address space with a zero-wait memory.
    assign data_w = mem_word(addr_w);

    if_block #(.WIDTH(64), .RESET_PC(64'hFFFF_FFFF_FFFF_FFF8)) dut_w (
        .p_clk(p_clk), .p_reset(p_reset), .p_Stall(1'b0),
        .p_Redirect(1'b0), .p_RedirectPC(64'h0),
        .p_IMEM_Req(req_w), .p_IMEM_Addr(addr_w),
        .p_IMEM_Ack(1'b1), .p_IMEM_Data(data_w),
        .p_IF_OUT_Instruction(instr_w),
        .p_IF_OUT_PC(pc_w), .p_IF_OUT_Valid(valid_w)
    );

    initial p_clk = 1'b0;
    always #5 p_clk = ~p_clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One clock: drive inputs, predict from the rules, advance, compare.
    task automatic cyc(input logic a, input logic s, input logic r, input logic [63:0] t);
        logic        ack_g;
        logic        exp_req, chk_req, chk_addr;
        logic [63:0] exp_addr, pre_addr, tgt;
        ack_g        = a & p_IMEM_Req;
        pre_addr     = p_IMEM_Addr;
        p_IMEM_Ack   = ack_g;
        p_IMEM_Data  = ack_g ? mem_word(p_IMEM_Addr) : 32'($urandom());
        p_Stall      = s;
        p_Redirect   = r;
        p_RedirectPC = t;
        chk_req  = 1'b0;
        chk_addr = 1'b0;
        exp_req  = 1'b0;
        exp_addr = '0;
        if (p_reset) begin
            m_valid = 1'b0; m_buf = 1'b0; m_stale = 1'b0;
            m_pc = '0; m_instr = '0; stream = '0;
            chk_req = 1'b1; chk_addr = 1'b1;
        end else begin
            if (m_valid && !s && !r) begin
                chk("stream_pc", p_IF_OUT_PC, stream);
                chk("stream_instr", 64'(p_IF_OUT_Instruction), 64'(mem_word(stream)));
                stream   = stream + 64'd4;
                consumed++;
            end
            if (r) begin
                tgt     = t & ~64'h3;
                m_valid = 1'b0;
                m_buf   = 1'b0;
                stream  = tgt;
                chk_req = 1'b1; chk_addr = 1'b1; exp_req = 1'b1;
                if (p_IMEM_Req && (m_stale || !ack_g)) begin
                    m_stale  = 1'b1;
                    exp_addr = pre_addr;
                end else begin
                    m_stale  = 1'b0;
                    exp_addr = tgt;
                end
            end else if (ack_g && m_stale) begin
                m_stale = 1'b0;
                if (!s) m_valid = 1'b0;
                chk_req = 1'b1; chk_addr = 1'b1; exp_req = 1'b1; exp_addr = stream;
            end else if (ack_g) begin
                chk_req = 1'b1;
                if (!s || !m_valid) begin
                    m_valid = 1'b1; m_pc = pre_addr; m_instr = mem_word(pre_addr);
                    chk_addr = 1'b1; exp_req = 1'b1; exp_addr = pre_addr + 64'd4;
                end else begin
                    m_buf = 1'b1; m_buf_pc = pre_addr;
                end
            end else if (m_buf && !s) begin
                m_valid = 1'b1; m_pc = m_buf_pc; m_instr = mem_word(m_buf_pc); m_buf = 1'b0;
                chk_req = 1'b1; chk_addr = 1'b1; exp_req = 1'b1; exp_addr = m_buf_pc + 64'd4;
            end else begin
                if (!s) m_valid = 1'b0;
                if (m_buf) begin
                    chk_req = 1'b1;
                end else if (p_IMEM_Req) begin
                    chk_req = 1'b1; chk_addr = 1'b1; exp_req = 1'b1; exp_addr = pre_addr;
                end
            end
        end
        @(posedge p_clk);
        #1;
        chk("valid", 64'(p_IF_OUT_Valid), 64'(m_valid));
        if (m_valid) begin
            chk("out_pc", p_IF_OUT_PC, m_pc);
            chk("out_instr", 64'(p_IF_OUT_Instruction), 64'(m_instr));
        end
        if (chk_req)  chk("imem_req", 64'(p_IMEM_Req), 64'(exp_req));
        if (chk_addr) chk("imem_addr", p_IMEM_Addr, exp_addr);
    endtask

    initial begin
        logic [63:0] want;
        logic        a, s, r, started;
        logic [63:0] t;
        int          wl;

        p_reset = 1'b1; p_Stall = 1'b0; p_Redirect = 1'b0; p_RedirectPC = '0;
        p_IMEM_Ack = 1'b0; p_IMEM_Data = '0; consumed = 0;
        m_valid = 1'b0; m_buf = 1'b0; m_stale = 1'b0; m_pc = '0; m_buf_pc = '0;
        m_instr = '0; stream = '0;
        #2;

        // Reset state
        cyc(1'b0, 1'b0, 1'b0, 64'h0);
        cyc(1'b0, 1'b0, 1'b0, 64'h0);
        chk("rst_out_pc", p_IF_OUT_PC, 64'h0);
        chk("rst_out_instr", 64'(p_IF_OUT_Instruction), 64'h0);
        chk("rst_w_addr", addr_w, 64'hFFFF_FFFF_FFFF_FFF8);
        chk("rst_w_req", 64'(req_w), 64'h0);
        p_reset = 1'b0;

        // Zero-wait fetch from reset, both instances
        cyc(1'b1, 1'b0, 1'b0, 64'h0);
        chk("first_req", 64'(p_IMEM_Req), 64'h1);
        chk("first_addr", p_IMEM_Addr, 64'h0);
        want = 64'hFFFF_FFFF_FFFF_FFF8;
        for (int i = 0; i < 4; i++) begin
            cyc(1'b1, 1'b0, 1'b0, 64'h0);
            chk("seq_pc", p_IF_OUT_PC, 64'(4 * i));
            chk("seq_valid", 64'(p_IF_OUT_Valid), 64'h1);
            chk("wrap_pc", pc_w, want);
            chk("wrap_instr", 64'(instr_w), 64'(mem_word(want)));
            chk("wrap_valid", 64'(valid_w), 64'h1);
            want = want + 64'd4;
        end

        // Three wait states at 0x10
        chk("ws_addr0", p_IMEM_Addr, 64'h10);
        for (int i = 0; i < 3; i++) begin
            cyc(1'b0, 1'b0, 1'b0, 64'h0);
            chk("ws_addr", p_IMEM_Addr, 64'h10);
            chk("ws_valid", 64'(p_IF_OUT_Valid), 64'h0);
        end
        cyc(1'b1, 1'b0, 1'b0, 64'h0);
        chk("ws_out_pc", p_IF_OUT_PC, 64'h10);
        cyc(1'b0, 1'b0, 1'b0, 64'h0);
        chk("ws_after_valid", 64'(p_IF_OUT_Valid), 64'h0);

        // Stall while 0x20 acks
        for (int i = 0; i < 3; i++) cyc(1'b1, 1'b0, 1'b0, 64'h0);
        chk("pre_stall_pc", p_IF_OUT_PC, 64'h1C);
        for (int i = 0; i < 5; i++) begin
            cyc(1'b1, 1'b1, 1'b0, 64'h0);
            chk("stall_pc", p_IF_OUT_PC, 64'h1C);
            chk("stall_req", 64'(p_IMEM_Req), 64'h0);
        end
        cyc(1'b0, 1'b0, 1'b0, 64'h0);
        chk("release_pc", p_IF_OUT_PC, 64'h20);
        chk("release_req", 64'(p_IMEM_Req), 64'h1);
        cyc(1'b1, 1'b0, 1'b0, 64'h0);
        chk("release_next_pc", p_IF_OUT_PC, 64'h24);

        // Redirect to 0x1003 with 0x40 outstanding for two wait states
        for (int i = 0; i < 6; i++) cyc(1'b1, 1'b0, 1'b0, 64'h0);
        chk("redir_pre_addr", p_IMEM_Addr, 64'h40);
        cyc(1'b0, 1'b0, 1'b1, 64'h1003);
        chk("redir_valid", 64'(p_IF_OUT_Valid), 64'h0);
        chk("redir_stale_addr", p_IMEM_Addr, 64'h40);
        cyc(1'b0, 1'b0, 1'b0, 64'h0);
        chk("redir_stale_addr2", p_IMEM_Addr, 64'h40);
        cyc(1'b1, 1'b0, 1'b0, 64'h0);
        chk("redir_new_addr", p_IMEM_Addr, 64'h1000);
        chk("redir_dropped", 64'(p_IF_OUT_Valid), 64'h0);
        cyc(1'b1, 1'b0, 1'b0, 64'h0);
        chk("redir_out_pc", p_IF_OUT_PC, 64'h1000);

        // Redirect during HOLD under stall
        cyc(1'b1, 1'b1, 1'b0, 64'h0);
        chk("hold_req", 64'(p_IMEM_Req), 64'h0);
        cyc(1'b0, 1'b1, 1'b1, 64'h2000);
        chk("hold_redir_valid", 64'(p_IF_OUT_Valid), 64'h0);
        chk("hold_redir_addr", p_IMEM_Addr, 64'h2000);
        cyc(1'b1, 1'b0, 1'b0, 64'h0);
        chk("hold_redir_pc", p_IF_OUT_PC, 64'h2000);

        // Randomized traffic
        consumed = 0;
        started  = 1'b0;
        wl       = 0;
        for (int i = 0; i < 3000; i++) begin
            s = ($urandom_range(0, 9) < 3);
            r = ($urandom_range(0, 19) == 0);
            t = {32'($urandom()), 32'($urandom())};
            if ($urandom_range(0, 3) == 0) t = 64'hFFFF_FFFF_FFFF_FFE0 | 64'($urandom_range(0, 31));
            a = 1'b0;
            if (p_IMEM_Req) begin
                if (!started) begin
                    wl = ($urandom_range(0, 3) == 3) ? 3 : int'($urandom_range(0, 1));
                    started = 1'b1;
                end
                a = (wl == 0);
                if (a) started = 1'b0;
                else   wl--;
            end
            cyc(a, s, r, t);
        end
        chk("progress", 64'(consumed > 300), 64'h1);

        // Reset with a request pending
        p_reset = 1'b1;
        cyc(1'b1, 1'b0, 1'b0, 64'h0);
        chk("midrst_valid", 64'(p_IF_OUT_Valid), 64'h0);
        p_reset = 1'b0;
        cyc(1'b1, 1'b0, 1'b0, 64'h0);
        chk("midrst_req", 64'(p_IMEM_Req), 64'h1);
        chk("midrst_addr", p_IMEM_Addr, 64'h0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end

endmodule
